mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of Execute. Takes ALU result (address or
//  pass-through value), store data and dest register; runs a req/ack handshake
//  to data memory for loads/stores; stalls upstream while an access is open.
//  Sized/sign-extended load data or ALU result is registered for writeback.
// PARAMETERS
//  TIMEOUT_CYCLES  255  ACCESS cycles allowed without DMemAck before BusErr; 0 = never time out
// PORTS
//  Clk           in   1   clock, rising edge
//  Reset         in   1   synchronous, active-low reset
//  InValid       in   1   valid op from Execute this cycle
//  ALUResult     in   32  byte address (mem op) or result (non-mem op)
//  StoreData     in   32  store source register value
//  WriteRegIn    in   5   destination register from RegDst mux
//  RegWriteIn    in   1   op writes register file
//  MemRead       in   1   load
//  MemWrite      in   1   store; wins if MemRead is also 1
//  MemSize       in   2   00 byte, 01 half, 10/11 word
//  MemSignExt    in   1   sign-extend sub-word loads (else zero-extend)
//  Stall         out  1   hold upstream; =1 exactly while state==ACCESS
//  DMemReq       out  1   memory request
//  DMemWe        out  1   1 = write
//  DMemAddr      out  32  word address, [1:0]=00
//  DMemWData     out  32  lane-replicated store data
//  DMemBE        out  4   byte enables, bit i = bits [8i+7:8i]
//  DMemAck       in   1   request completes this cycle; load data valid
//  DMemRData     in   32  load data word
//  OutValid      out  1   one-cycle pulse, writeback fields valid
//  WriteData     out  32  load result or ALU result
//  WriteRegister out  5   destination register
//  RegWrite      out  1   writeback enable, qualified by OutValid
//  AlignErr      out  1   pulse with OutValid: misaligned access
//  BusErr        out  1   pulse with OutValid: access timed out
// BEHAVIOUR
//  Reset (Reset==0 at edge): state IDLE, counter 0, all outputs 0.
//  FSM IDLE/ACCESS. Little-endian lanes; lane = addr[1:0].
//  IDLE, InValid, no mem op: next cycle OutValid=1, WriteData=ALUResult,
//   RegWrite=RegWriteIn, WriteRegister=WriteRegIn. One instr/cycle, no stall.
//  IDLE, InValid, aligned mem op: capture op and address; next state ACCESS.
//  ACCESS: DMemReq=1; Addr/We/WData/BE stable until ack; InValid ignored.
//   Ack sampled high: -> IDLE; next cycle OutValid=1. Load: RegWrite=RegWriteIn.
//   Store: RegWrite=0. Best case: accept N, req+ack N+1, OutValid N+2.
//  Byte: BE=1<<lane, WData={4{b}}. Half: BE=0011/1100 by addr[1],
//   WData={2{h}}. Word: BE=1111.
//  Load data: DMemRData >> 8*lane, then ext 8/16 -> 32 per MemSignExt.
//  Misaligned (half addr[0]=1; word addr[1:0]!=0): no request, no ACCESS.
//   Next cycle OutValid=1, AlignErr=1, RegWrite=0.
//  Timeout: counter clears on entering ACCESS and increments each ACCESS cycle
//   without ack. At TIMEOUT_CYCLES: DMemReq drops, -> IDLE; next cycle
//   OutValid=1, BusErr=1, RegWrite=0. Ack on the timeout cycle wins.
//  DMemAck in IDLE is ignored. Reset mid-ACCESS drops DMemReq at that edge;
//   a late ack is ignored.
//  When OutValid=0: RegWrite/AlignErr/BusErr=0; WriteData/WriteRegister hold.
// TESTING
//  ALU op, ALUResult=0x1234, reg 5, RegWriteIn=1 -> next cycle OutValid,
//   WriteData=0x1234, RegWrite=1, Stall never 1.
//  LB addr 0x103, SignExt=1, RData=0x80FFFFFF, ack after 3 cycles
//   -> DMemAddr=0x100, Stall 3 cycles, WriteData=0xFFFFFF80.
//  SH addr 0x22, StoreData=0xABCDBEEF, ack 1st cycle -> BE=1100,
//   WData=0xBEEFBEEF, DMemWe=1, OutValid with RegWrite=0.
//  LW addr 0x101 -> no DMemReq, OutValid+AlignErr next cycle, RegWrite=0.
//  TIMEOUT_CYCLES=4, no ack -> DMemReq exactly 4 cycles, then BusErr pulse;
//   Reset=0 during ACCESS -> DMemReq=0 next cycle, later ack ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage between Execute and Writeback: runs a req/ack data-memory access
// for loads/stores, stalls upstream while it is open, and registers writeback fields.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  input  logic [4:0]  WriteRegIn,
  input  logic        RegWriteIn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSignExt,
  output logic        Stall,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemBE,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic        OutValid,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic        AlignErr,
  output logic        BusErr
);

  // Memory handshake: DMemReq stays high with Addr/We/WData/BE frozen until a
  // cycle in which DMemAck is sampled high (or the timeout fires); DMemAck is
  // only meaningful while DMemReq is high.
  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q, sext_q, regwr_q;
  logic [1:0]  lane_q, size_q;
  logic [4:0]  wreg_q;

  logic        out_valid_q, regwrite_q, align_q, bus_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_reg_q;

  logic        mem_op, misaligned, accept_idle, start_access;
  logic        in_access, ack_hit, timeout_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, shifted, load_result;

  assign mem_op      = MemRead | MemWrite;
  assign misaligned  = (MemSize == 2'b01) ? ALUResult[0] :
                       (MemSize[1] ? (ALUResult[1:0] != 2'b00) : 1'b0);
  assign in_access   = (state_q == S_ACCESS);
  assign accept_idle = (state_q == S_IDLE) & InValid;
  assign start_access = accept_idle & mem_op & ~misaligned;
  assign ack_hit     = in_access & DMemAck;
  assign timeout_hit = in_access & ~DMemAck & (TIMEOUT_CYCLES != 0) & (cnt_q == CNT_LAST);

  // Lane steering for the store side: replicate data so any enabled lane sees it.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = StoreData;
    case (MemSize)
      2'b00: begin
        be_d    = 4'b0001 << ALUResult[1:0];
        wdata_d = {4{StoreData[7:0]}};
      end
      2'b01: begin
        be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{StoreData[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = StoreData;
      end
    endcase
  end

  always_comb begin
    shifted     = DMemRData >> {lane_q, 3'b000};
    load_result = shifted;
    case (size_q)
      2'b00:   load_result = sext_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      2'b01:   load_result = sext_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: load_result = shifted;
    endcase
  end

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_access) state_d = S_ACCESS;
      S_ACCESS: if (DMemAck || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; bus fields read as zero outside an access
  always_comb begin
    Stall     = in_access;
    DMemReq   = in_access;
    DMemWe    = in_access & we_q;
    DMemAddr  = in_access ? addr_q : 32'b0;
    DMemWData = in_access ? wdata_q : 32'b0;
    DMemBE    = in_access ? be_q : 4'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (start_access) begin
      cnt_q <= '0;
    end else if (in_access && !DMemAck) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      regwr_q <= 1'b0;
      lane_q  <= '0;
      size_q  <= '0;
      wreg_q  <= '0;
    end else if (start_access) begin
      addr_q  <= {ALUResult[31:2], 2'b00};
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= MemWrite;
      sext_q  <= MemSignExt;
      regwr_q <= RegWriteIn;
      lane_q  <= ALUResult[1:0];
      size_q  <= MemSize;
      wreg_q  <= WriteRegIn;
    end
  end

  // Writeback register: pulses clear every cycle, data/register hold between pulses.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_valid_q <= 1'b0;
      regwrite_q  <= 1'b0;
      align_q     <= 1'b0;
      bus_q       <= 1'b0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      regwrite_q  <= 1'b0;
      align_q     <= 1'b0;
      bus_q       <= 1'b0;
      if (accept_idle && !mem_op) begin
        out_valid_q <= 1'b1;
        regwrite_q  <= RegWriteIn;
        wb_data_q   <= ALUResult;
        wb_reg_q    <= WriteRegIn;
      end else if (accept_idle && misaligned) begin
        out_valid_q <= 1'b1;
        align_q     <= 1'b1;
        wb_reg_q    <= WriteRegIn;
      end else if (ack_hit) begin
        out_valid_q <= 1'b1;
        regwrite_q  <= ~we_q & regwr_q;
        wb_reg_q    <= wreg_q;
        if (!we_q) wb_data_q <= load_result;
      end else if (timeout_hit) begin
        out_valid_q <= 1'b1;
        bus_q       <= 1'b1;
        wb_reg_q    <= wreg_q;
      end
    end
  end

  assign OutValid      = out_valid_q;
  assign RegWrite      = regwrite_q;
  assign AlignErr      = align_q;
  assign BusErr        = bus_q;
  assign WriteData     = wb_data_q;
  assign WriteRegister = wb_reg_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, sized loads/stores,
// misalignment, timeout, ack-on-timeout and reset during an open access.
module tb_mem_access_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic [31:0] ALUResult, StoreData;
  logic [4:0]  WriteRegIn;
  logic        RegWriteIn, MemRead, MemWrite, MemSignExt;
  logic [1:0]  MemSize;
  logic        Stall, DMemReq, DMemWe, DMemAck;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]  DMemBE;
  logic        OutValid, RegWrite, AlignErr, BusErr;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;

  int n_pass = 0;
  int n_total = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .ALUResult(ALUResult),
    .StoreData(StoreData), .WriteRegIn(WriteRegIn), .RegWriteIn(RegWriteIn),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSignExt(MemSignExt),
    .Stall(Stall), .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemBE(DMemBE), .DMemAck(DMemAck), .DMemRData(DMemRData),
    .OutValid(OutValid), .WriteData(WriteData), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite), .AlignErr(AlignErr), .BusErr(BusErr)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive_op(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] wr, input logic rw, input logic mr,
                          input logic mw, input logic [1:0] sz, input logic sx);
    InValid = v; ALUResult = alu; StoreData = sd; WriteRegIn = wr; RegWriteIn = rw;
    MemRead = mr; MemWrite = mw; MemSize = sz; MemSignExt = sx;
  endtask

  initial begin
    Reset = 1'b0; DMemAck = 1'b0; DMemRData = 32'h0;
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(); step();
    chk("rst_outvalid", OutValid, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_req", DMemReq, 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_regwrite", RegWrite, 0);
    Reset = 1'b1;
    step();

    // ALU pass-through
    drive_op(1, 32'h1234, 0, 5'd5, 1, 0, 0, 2'b10, 0);
    step();
    chk("alu_outvalid", OutValid, 1);
    chk("alu_wdata", WriteData, 32'h1234);
    chk("alu_wreg", WriteRegister, 5);
    chk("alu_regwrite", RegWrite, 1);
    chk("alu_stall", Stall, 0);
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step();
    chk("alu_pulse_end", OutValid, 0);
    chk("alu_rw_clear", RegWrite, 0);
    chk("alu_wdata_hold", WriteData, 32'h1234);

    // LB 0x103 sign-extended, ack in third access cycle; InValid ignored meanwhile
    drive_op(1, 32'h103, 0, 5'd7, 1, 1, 0, 2'b00, 1);
    step();
    chk("lb_stall_c1", Stall, 1);
    chk("lb_req_c1", DMemReq, 1);
    chk("lb_addr_c1", DMemAddr, 32'h100);
    chk("lb_we", DMemWe, 0);
    chk("lb_be", DMemBE, 4'b1000);
    drive_op(1, 32'hFFFF, 0, 5'd9, 1, 0, 0, 2'b10, 0);
    DMemRData = 32'h80FFFFFF;
    step();
    chk("lb_stall_c2", Stall, 1);
    chk("lb_addr_c2", DMemAddr, 32'h100);
    chk("lb_noout_c2", OutValid, 0);
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step();
    chk("lb_stall_c3", Stall, 1);
    chk("lb_noout_c3", OutValid, 0);
    DMemAck = 1'b1;
    step();
    DMemAck = 1'b0;
    chk("lb_stall_done", Stall, 0);
    chk("lb_req_done", DMemReq, 0);
    chk("lb_outvalid", OutValid, 1);
    chk("lb_wdata", WriteData, 32'hFFFFFF80);
    chk("lb_regwrite", RegWrite, 1);
    chk("lb_wreg", WriteRegister, 7);

    // SH 0x22, ack first cycle
    drive_op(1, 32'h22, 32'hABCDBEEF, 5'd3, 1, 0, 1, 2'b01, 0);
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("sh_req", DMemReq, 1);
    chk("sh_we", DMemWe, 1);
    chk("sh_addr", DMemAddr, 32'h20);
    chk("sh_be", DMemBE, 4'b1100);
    chk("sh_wdata", DMemWData, 32'hBEEFBEEF);
    DMemAck = 1'b1;
    step();
    DMemAck = 1'b0;
    chk("sh_outvalid", OutValid, 1);
    chk("sh_regwrite", RegWrite, 0);
    chk("sh_alignerr", AlignErr, 0);

    // SB 0x11: lane 1
    drive_op(1, 32'h11, 32'h12345678, 5'd3, 0, 0, 1, 2'b00, 0);
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("sb_be", DMemBE, 4'b0010);
    chk("sb_wdata", DMemWData, 32'h78787878);
    chk("sb_addr", DMemAddr, 32'h10);
    DMemAck = 1'b1;
    step();
    DMemAck = 1'b0;
    chk("sb_outvalid", OutValid, 1);

    // LH 0x42 zero-extended
    drive_op(1, 32'h42, 0, 5'd12, 1, 1, 0, 2'b01, 0);
    DMemRData = 32'h80011234;
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("lh_be", DMemBE, 4'b1100);
    DMemAck = 1'b1;
    step();
    DMemAck = 1'b0;
    chk("lh_wdata", WriteData, 32'h00008001);
    chk("lh_wreg", WriteRegister, 12);
    chk("lh_regwrite", RegWrite, 1);

    // LW 0x101 misaligned
    drive_op(1, 32'h101, 0, 5'd4, 1, 1, 0, 2'b10, 0);
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("lw_mis_req", DMemReq, 0);
    chk("lw_mis_stall", Stall, 0);
    chk("lw_mis_outvalid", OutValid, 1);
    chk("lw_mis_alignerr", AlignErr, 1);
    chk("lw_mis_regwrite", RegWrite, 0);
    step();
    chk("lw_mis_pulse_end", AlignErr, 0);
    chk("lw_mis_req_after", DMemReq, 0);

    // LW 0x300, no ack: four request cycles then BusErr
    drive_op(1, 32'h300, 0, 5'd6, 1, 1, 0, 2'b10, 0);
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_c%0d", i + 1), DMemReq, 1);
      chk($sformatf("to_noout_c%0d", i + 1), OutValid, 0);
      step();
    end
    chk("to_req_drop", DMemReq, 0);
    chk("to_outvalid", OutValid, 1);
    chk("to_buserr", BusErr, 1);
    chk("to_regwrite", RegWrite, 0);
    step();
    chk("to_buserr_end", BusErr, 0);

    // LW 0x400, ack on the timeout cycle wins
    drive_op(1, 32'h400, 0, 5'd8, 1, 1, 0, 2'b11, 0);
    DMemRData = 32'h11223344;
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(); step(); step();
    chk("ackto_req_c4", DMemReq, 1);
    DMemAck = 1'b1;
    step();
    DMemAck = 1'b0;
    chk("ackto_outvalid", OutValid, 1);
    chk("ackto_buserr", BusErr, 0);
    chk("ackto_regwrite", RegWrite, 1);
    chk("ackto_wdata", WriteData, 32'h11223344);

    // Reset during ACCESS; a late ack must be ignored
    drive_op(1, 32'h500, 0, 5'd2, 1, 1, 0, 2'b10, 0);
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("rstacc_req", DMemReq, 1);
    Reset = 1'b0;
    step();
    chk("rstacc_req_drop", DMemReq, 0);
    chk("rstacc_stall", Stall, 0);
    chk("rstacc_outvalid", OutValid, 0);
    Reset = 1'b1;
    DMemAck = 1'b1;
    step();
    DMemAck = 1'b0;
    chk("late_ack_outvalid", OutValid, 0);
    chk("late_ack_req", DMemReq, 0);
    step();
    chk("late_ack_outvalid2", OutValid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
